apb_controller: RTL and testbench

- Downstream stage of ahb_slave in the AHB-to-APB bridge.
- Consumes the slave's registered transfer request (VALID, HADDR_TEMP, HWDATA_TEMP, HWRITE_TEMP) and runs one APB SETUP/ACCESS transfer per request.
- Stalls the AHB side through HREADYOUT until that transfer completes.
- Returns read data and error status; bounds APB wait states with a timeout counter.

---
 rtl/apb_controller.sv | 121 ++++++++++++
 tb/tb_apb_controller.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_controller.sv
// apb_controller: runs one APB SETUP/ACCESS transfer for each request from ahb_slave.
// Latency: with zero APB wait states, a write holds HREADYOUT low for 3 cycles and a read for 2.
// Backpressure: HREADYOUT stays low until the transfer completes or times out. VALID is ignored while HREADYOUT is low.
//
// Ports:
//   HCLK, HRESET             clock and synchronous active-high reset
//   VALID, HADDR_TEMP,       transfer request from ahb_slave. HWDATA_TEMP
//   HWRITE_TEMP, HWDATA_TEMP is valid in the cycle after the request is accepted.
//   HREADYOUT, HRESP, HRDATA AHB-side completion handshake, error flag and read data
//   PSEL, PENABLE, PWRITE,   APB master outputs (PSEL is one-hot)
//   PADDR, PWDATA
//   PRDATA, PREADY, PSLVERR  APB slave response
module apb_controller #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int NSLV     = 4,
  parameter int SEL_LSB  = 12,
  parameter int WAIT_MAX = 16
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              VALID,
  input  logic [ADDR_W-1:0] HADDR_TEMP,
  input  logic              HWRITE_TEMP,
  input  logic [DATA_W-1:0] HWDATA_TEMP,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [DATA_W-1:0] HRDATA,
  output logic [NSLV-1:0]   PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA
);

  localparam int SEL_W = $clog2(NSLV);
  localparam int CNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

  typedef enum logic [1:0] {IDLE, WDATA, SETUP, ACCESS} state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [SEL_W-1:0] sel_idx;
  logic [NSLV-1:0]  sel_onehot;

  // PSEL is registered on entry to SETUP. A read enters SETUP straight from IDLE,
  // before PADDR holds the new address, so the slave field is taken from the request.
  // A write enters SETUP from WDATA, where PADDR is already latched.
  assign sel_idx    = (state == IDLE) ? HADDR_TEMP[SEL_LSB +: SEL_W] : PADDR[SEL_LSB +: SEL_W];
  assign sel_onehot = {{(NSLV-1){1'b0}}, 1'b1} << sel_idx;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      HRDATA    <= '0;
      PSEL      <= '0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (VALID) begin
            PADDR     <= HADDR_TEMP;
            PWRITE    <= HWRITE_TEMP;
            HRESP     <= 1'b0;
            HREADYOUT <= 1'b0;
            if (HWRITE_TEMP) begin
              state <= WDATA;
            end else begin
              PSEL  <= sel_onehot;
              state <= SETUP;
            end
          end
        end
        WDATA: begin
          // AHB data phase: write data arrives one cycle after the address
          PWDATA <= HWDATA_TEMP;
          PSEL   <= sel_onehot;
          state  <= SETUP;
        end
        SETUP: begin
          PENABLE  <= 1'b1;
          wait_cnt <= '0;
          state    <= ACCESS;
        end
        ACCESS: begin
          // A PREADY in the timeout cycle still counts as a normal completion
          if (PREADY) begin
            if (!PWRITE) begin
              HRDATA <= PRDATA;
            end
            HRESP     <= PSLVERR;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            HREADYOUT <= 1'b1;
            state     <= IDLE;
          end else if (wait_cnt == CNT_LAST) begin
            HRESP     <= 1'b1;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            HREADYOUT <= 1'b1;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_controller.sv
// Bench for apb_controller: directed transfers with literal expectations, then random traffic.
// Each negedge compares every DUT output against a transaction-level model.
module tb_apb_controller;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int NSLV     = 4;
  localparam int SEL_LSB  = 12;
  localparam int WAIT_MAX = 16;
  localparam int SEL_W    = $clog2(NSLV);

  logic              HCLK = 1'b0;
  logic              HRESET, VALID, HWRITE_TEMP, PREADY, PSLVERR;
  logic [ADDR_W-1:0] HADDR_TEMP;
  logic [DATA_W-1:0] HWDATA_TEMP, PRDATA;
  logic              HREADYOUT, HRESP, PENABLE, PWRITE;
  logic [DATA_W-1:0] HRDATA, PWDATA;
  logic [NSLV-1:0]   PSEL;
  logic [ADDR_W-1:0] PADDR;

  apb_controller #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NSLV(NSLV), .SEL_LSB(SEL_LSB), .WAIT_MAX(WAIT_MAX)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .VALID(VALID), .HADDR_TEMP(HADDR_TEMP),
    .HWRITE_TEMP(HWRITE_TEMP), .HWDATA_TEMP(HWDATA_TEMP), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .HRDATA(HRDATA), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA)
  );

  always #5 HCLK = ~HCLK;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // One transfer = accept, [one data-phase cycle for writes], one setup cycle,
  // then access cycles until PREADY or WAIT_MAX access cycles have elapsed.
  logic              m_on = 1'b0;
  logic              m_busy, m_wr, m_rdy, m_resp, m_pwrite;
  int                m_t;                 // cycles elapsed since the accept edge
  logic [ADDR_W-1:0] m_paddr;
  logic [DATA_W-1:0] m_rdata, m_pwdata;

  function automatic logic [NSLV-1:0] onehot(input logic [ADDR_W-1:0] a);
    logic [NSLV-1:0] v;
    v = '0;
    v[a[SEL_LSB +: SEL_W]] = 1'b1;
    return v;
  endfunction

  always @(negedge HCLK) begin
    int so, k;
    logic [NSLV-1:0] e_psel;
    logic e_pen;
    so = m_wr ? 2 : 1;                    // offset of the setup cycle from the accept
    if (m_on) begin
      e_psel = (m_busy && m_t >= so) ? onehot(m_paddr) : '0;
      e_pen  = m_busy && (m_t > so);
      chk("HREADYOUT", HREADYOUT, m_rdy);
      chk("HRESP", HRESP, m_resp);
      chk("HRDATA", HRDATA, m_rdata);
      chk("PSEL", PSEL, e_psel);
      chk("PENABLE", PENABLE, e_pen);
      chk("PWRITE", PWRITE, m_pwrite);
      chk("PADDR", PADDR, m_paddr);
      chk("PWDATA", PWDATA, m_pwdata);
    end
    // advance the model with the inputs the next rising edge will sample
    if (HRESET) begin
      m_on = 1'b1; m_busy = 1'b0; m_wr = 1'b0; m_t = 0; m_rdy = 1'b1; m_resp = 1'b0;
      m_rdata = '0; m_pwrite = 1'b0; m_paddr = '0; m_pwdata = '0;
    end else if (m_on) begin
      if (!m_busy) begin
        if (VALID) begin
          m_busy = 1'b1; m_t = 1; m_wr = HWRITE_TEMP; m_pwrite = HWRITE_TEMP;
          m_paddr = HADDR_TEMP; m_resp = 1'b0; m_rdy = 1'b0;
        end
      end else if (m_t > so) begin
        k = m_t - so - 1;                 // index of the current access cycle
        if (PREADY) begin
          if (!m_wr) m_rdata = PRDATA;
          m_resp = PSLVERR; m_busy = 1'b0; m_rdy = 1'b1;
        end else if (k == WAIT_MAX - 1) begin
          m_resp = 1'b1; m_busy = 1'b0; m_rdy = 1'b1;
        end else begin
          m_t++;
        end
      end else begin
        if (m_wr && m_t == 1) m_pwdata = HWDATA_TEMP;
        m_t++;
      end
    end
  end

  // ---------------- APB slave responder ----------------
  typedef struct {
    int              wait_n;
    logic            err;
    logic [DATA_W-1:0] data;
  } rsp_t;
  rsp_t rsp_q[$];
  rsp_t cur;
  int   acc_k = 0;
  logic pen_q = 1'b0;

  always @(posedge HCLK) begin
    #1;
    if (PENABLE) begin
      if (!pen_q) begin
        acc_k = 0;
        if (rsp_q.size() > 0) cur = rsp_q.pop_front();
        else begin cur.wait_n = 0; cur.err = 1'b0; cur.data = '0; end
      end else begin
        acc_k++;
      end
      PREADY  = (acc_k >= cur.wait_n);
      PRDATA  = cur.data;
      PSLVERR = cur.err;
    end else begin
      // outside ACCESS the response lines are don't-care: keep them noisy
      PREADY  = 1'($urandom_range(0, 1));
      PRDATA  = $urandom;
      PSLVERR = 1'($urandom_range(0, 1));
    end
    pen_q = PENABLE;
  end

  // ---------------- monitor for directed literal checks ----------------
  int                lo_cnt, setup_cnt, pen_cnt, n_setup, cyc;
  logic [NSLV-1:0]   setup_psel;
  logic              apb_moved;
  int                setup_cyc [4];
  logic [ADDR_W-1:0] setup_addr [4];
  logic [DATA_W-1:0] setup_wd [4];

  task automatic clear_mon();
    lo_cnt = 0; setup_cnt = 0; pen_cnt = 0; n_setup = 0; apb_moved = 1'b0; setup_psel = '0;
  endtask

  always @(negedge HCLK) begin
    cyc++;
    if (!HREADYOUT) lo_cnt++;
    if (PSEL != '0 && !PENABLE) begin
      setup_cnt++;
      setup_psel = PSEL;
      if (n_setup < 4) begin
        setup_cyc[n_setup] = cyc; setup_addr[n_setup] = PADDR; setup_wd[n_setup] = PWDATA;
        n_setup++;
      end
    end
    if (PENABLE) begin
      pen_cnt++;
      if (n_setup > 0 && (PADDR !== setup_addr[n_setup-1] || PWDATA !== setup_wd[n_setup-1]))
        apb_moved = 1'b1;
    end
  end

  // ---------------- AHB-side driver ----------------
  task automatic tick();
    @(posedge HCLK); #2;
  endtask

  // Called at posedge+2; returns at posedge+2 after the accepting edge.
  task automatic send(input logic [ADDR_W-1:0] addr, input logic wr, input logic [DATA_W-1:0] wd,
                      input int wn, input logic er, input logic [DATA_W-1:0] rd);
    rsp_t r;
    logic rdy;
    logic ok;
    r.wait_n = wn; r.err = er; r.data = rd;
    rsp_q.push_back(r);
    VALID = 1'b1; HADDR_TEMP = addr; HWRITE_TEMP = wr;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge HCLK); rdy = HREADYOUT;
      @(posedge HCLK); #2;
      ok = rdy;
    end
    chk("accept_timeout", ok, 1);
    HWDATA_TEMP = wd;
    VALID = 1'b0; HADDR_TEMP = $urandom; HWRITE_TEMP = 1'($urandom_range(0, 1));
  endtask

  // Returns at the first negedge where HREADYOUT is high.
  task automatic wait_done();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge HCLK); ok = HREADYOUT;
    end
    chk("done_timeout", ok, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic ok;
    HRESET = 1'b1; VALID = 1'b0; HWRITE_TEMP = 1'b0; HADDR_TEMP = '0; HWDATA_TEMP = '0;
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0; cyc = 0;
    clear_mon();
    repeat (3) @(posedge HCLK);
    #2 HRESET = 1'b0;

    // reset state
    @(negedge HCLK);
    chk("rst_hreadyout", HREADYOUT, 1);
    chk("rst_hresp", HRESP, 0);
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_hrdata", HRDATA, 0);

    // single write, no wait states
    tick(); clear_mon();
    send(32'hA000_0000, 1'b1, 32'h1234_5678, 0, 1'b0, 32'h0);
    wait_done();
    chk("wr_low_cycles", lo_cnt, 3);
    chk("wr_setup_cycles", setup_cnt, 1);
    chk("wr_psel", setup_psel, 4'b0001);
    chk("wr_penable_cycles", pen_cnt, 1);
    chk("wr_pwdata", PWDATA, 32'h1234_5678);
    chk("wr_pwrite", PWRITE, 1);
    chk("wr_hresp", HRESP, 0);

    // read with two wait states
    tick(); clear_mon();
    send(32'hA000_3004, 1'b0, 32'h0, 2, 1'b0, 32'hDEAD_BEEF);
    wait_done();
    chk("rd_psel", setup_psel, 4'b1000);
    chk("rd_penable_cycles", pen_cnt, 3);
    chk("rd_low_cycles", lo_cnt, 4);
    chk("rd_hrdata", HRDATA, 32'hDEAD_BEEF);
    chk("rd_hresp", HRESP, 0);

    // back-to-back writes with VALID held
    tick(); clear_mon();
    send(32'hA000_0008, 1'b1, 32'hABCD_EF01, 0, 1'b0, 32'h0);
    send(32'hA000_0010, 1'b1, 32'hFEDC_BA98, 0, 1'b0, 32'h0);
    wait_done();
    chk("b2b_setups", n_setup, 2);
    chk("b2b_spacing", setup_cyc[1] - setup_cyc[0], 4);
    chk("b2b_addr0", setup_addr[0], 32'hA000_0008);
    chk("b2b_addr1", setup_addr[1], 32'hA000_0010);
    chk("b2b_wdata0", setup_wd[0], 32'hABCD_EF01);
    chk("b2b_wdata1", setup_wd[1], 32'hFEDC_BA98);
    chk("b2b_apb_stable", apb_moved, 0);

    // read that never gets PREADY: timeout
    tick(); clear_mon();
    send(32'hA000_1000, 1'b0, 32'h0, 1000, 1'b0, 32'h1111_2222);
    wait_done();
    chk("to_penable_cycles", pen_cnt, 16);
    chk("to_low_cycles", lo_cnt, 17);
    chk("to_hresp", HRESP, 1);
    chk("to_hrdata_kept", HRDATA, 32'hDEAD_BEEF);
    chk("to_psel", PSEL, 0);

    // slave error on write, cleared by the next read
    tick();
    send(32'hA000_2000, 1'b1, 32'h0F0F_0F0F, 0, 1'b1, 32'h0);
    wait_done();
    chk("err_hresp", HRESP, 1);
    tick();
    send(32'hA000_0004, 1'b0, 32'h0, 1, 1'b0, 32'h5555_AAAA);
    chk("err_hresp_cleared", HRESP, 0);
    wait_done();
    chk("err_rd_hresp", HRESP, 0);
    chk("err_rd_hrdata", HRDATA, 32'h5555_AAAA);

    // reset in the middle of a write's access phase
    tick();
    send(32'hA000_3000, 1'b1, 32'h7777_8888, 1000, 1'b0, 32'h0);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge HCLK); ok = PENABLE;
    end
    chk("rst_reach_access", ok, 1);
    @(posedge HCLK); #2 HRESET = 1'b1;
    @(negedge HCLK);
    @(negedge HCLK);
    chk("mid_rst_hreadyout", HREADYOUT, 1);
    chk("mid_rst_psel", PSEL, 0);
    chk("mid_rst_penable", PENABLE, 0);
    chk("mid_rst_pwrite", PWRITE, 0);
    chk("mid_rst_paddr", PADDR, 0);
    chk("mid_rst_pwdata", PWDATA, 0);
    chk("mid_rst_hrdata", HRDATA, 0);
    chk("mid_rst_hresp", HRESP, 0);
    @(posedge HCLK); #2 HRESET = 1'b0;
    tick(); clear_mon();
    send(32'hA000_1040, 1'b1, 32'hCAFE_F00D, 0, 1'b0, 32'h0);
    wait_done();
    chk("post_rst_pwdata", PWDATA, 32'hCAFE_F00D);
    chk("post_rst_psel", setup_psel, 4'b0010);
    chk("post_rst_hresp", HRESP, 0);
    chk("post_rst_penable_cycles", pen_cnt, 1);

    // random traffic checked by the model
    tick();
    for (int i = 0; i < 150; i++) begin
      logic wr;
      int   wn;
      wr = 1'($urandom_range(0, 1));
      wn = ($urandom_range(0, 7) == 0) ? 1000 : int'($urandom_range(0, 3));
      send($urandom, wr, $urandom, wn, 1'($urandom_range(0, 3) == 0), $urandom);
      if ($urandom_range(0, 2) == 0) begin
        wait_done();
        tick();
        repeat ($urandom_range(0, 2)) tick();
      end
    end
    wait_done();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
